// File: rtl/dmem_pkg.sv
// Shared constants and enums for the data-memory block mover.
package dmem_pkg;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 64;
    localparam int LEN_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        OP_COPY     = 2'b00,
        OP_FILL     = 2'b01,
        OP_CHECKSUM = 2'b10,
        OP_ILLEGAL  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RD   = 2'b01,
        S_WR   = 2'b10,
        S_DONE = 2'b11
    } state_e;
endpackage

// File: rtl/dmem_block_mover.sv
// Block COPY / FILL / XOR-checksum engine driving the data-memory port.
// Memory port outputs are decoded purely from the FSM state and latched
// command registers, so IDLE and DONE never touch memory.
module dmem_block_mover
    import dmem_pkg::*;
#(
    parameter int ADDR_W = dmem_pkg::ADDR_W,
    parameter int DATA_W = dmem_pkg::DATA_W,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] checksum,
    output logic [LEN_W-1:0]  words_done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write,
    output logic              mem_read,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_q
);

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DATA_W-1:0]   fill_q, fill_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic [DATA_W-1:0]   cks_q, cks_d;
    logic [LEN_W-1:0]    wd_q, wd_d;

    logic [LEN_W-1:0]    wd_inc;
    logic                last;

    // Words-done counter after this beat; "last" ends the command. Compared
    // for equality so lengths above the memory depth simply wrap addresses.
    assign wd_inc = wd_q + LEN_W'(1);
    assign last   = (wd_inc == len_q);

    // State and command registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_COPY;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
            buf_q   <= '0;
            cks_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
            buf_q   <= buf_d;
            cks_q   <= cks_d;
            wd_q    <= wd_d;
        end
    end

    // Next-state and register update logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        fill_d  = fill_q;
        buf_d   = buf_q;
        cks_d   = cks_q;
        wd_d    = wd_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op_e'(op);
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    len_d  = len;
                    fill_d = fill_value;
                    wd_d   = '0;
                    if (op_e'(op) == OP_CHECKSUM) cks_d = '0;
                    if (len == '0 || op_e'(op) == OP_ILLEGAL) state_d = S_DONE;
                    else if (op_e'(op) == OP_FILL)            state_d = S_WR;
                    else                                       state_d = S_RD;
                end
            end
            S_RD: begin
                if (op_q == OP_COPY) begin
                    buf_d   = mem_q;
                    state_d = S_WR;
                end else begin
                    cks_d = cks_q ^ mem_q;
                    wd_d  = wd_inc;
                    if (last) state_d = S_DONE;
                end
            end
            S_WR: begin
                wd_d = wd_inc;
                if (last)                 state_d = S_DONE;
                else if (op_q == OP_COPY) state_d = S_RD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory port and status outputs decoded from state.
    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        case (state_q)
            S_RD: begin
                mem_read    = 1'b1;
                mem_address = src_q + wd_q[ADDR_W-1:0];
            end
            S_WR: begin
                mem_write      = 1'b1;
                mem_address    = dst_q + wd_q[ADDR_W-1:0];
                mem_write_data = (op_q == OP_COPY) ? buf_q : fill_q;
            end
            default: ;
        endcase
    end

    assign busy       = (state_q == S_RD) || (state_q == S_WR);
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_DONE) && (op_q == OP_ILLEGAL);
    assign checksum   = cks_q;
    assign words_done = wd_q;

endmodule

// File: tb/tb_dmem_block_mover.sv
// Bench for dmem_block_mover: a data memory responder, a per-command
// expected-trace model derived from the command semantics, and literal checks.
module tb_dmem_block_mover;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [5:0]  src_addr, dst_addr;
    logic [6:0]  len;
    logic [63:0] fill_value;
    logic        busy, done, err;
    logic [63:0] checksum;
    logic [6:0]  words_done;
    logic [5:0]  mem_address;
    logic        mem_write, mem_read;
    logic [63:0] mem_write_data, mem_q;

    always #5 clk = ~clk;

    dmem_block_mover dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .fill_value(fill_value), .busy(busy), .done(done), .err(err),
        .checksum(checksum), .words_done(words_done),
        .mem_address(mem_address), .mem_write(mem_write), .mem_read(mem_read),
        .mem_write_data(mem_write_data), .mem_q(mem_q)
    );

    // Data memory responder with a backdoor preload port.
    logic [63:0] mem [64];
    logic        pl_we = 1'b0;
    logic [5:0]  pl_addr = '0;
    logic [63:0] pl_data = '0;
    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (mem_write) mem[mem_address] <= mem_write_data;
    end
    assign mem_q = mem[mem_address];

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference model state.
    typedef struct {
        logic        rd, wr, busy, done, err;
        logic [5:0]  addr;
        logic [63:0] wdata;
        logic [6:0]  wd;
        logic        chk_v;
        logic [63:0] chk;
    } exp_t;
    exp_t        expq[$];
    logic [63:0] ref_mem [64];
    logic [63:0] chk_model = '0;

    function automatic exp_t mk(logic rd, logic wr, logic [5:0] a, logic [63:0] d, logic [6:0] wd);
        exp_t e;
        e.rd = rd; e.wr = wr; e.busy = rd | wr; e.done = 1'b0; e.err = 1'b0;
        e.addr = a; e.wdata = d; e.wd = wd; e.chk_v = 1'b0; e.chk = '0;
        return e;
    endfunction

    // Expected cycle-by-cycle trace of a command, updating the memory image.
    task automatic build_trace(input logic [1:0] o, input logic [5:0] s, input logic [5:0] d,
                               input logic [6:0] n, input logic [63:0] f);
        exp_t e;
        logic [63:0] w;
        logic [5:0] a;
        if (o == 2'b10) chk_model = '0;
        if (o != 2'b11) begin
            for (int i = 0; i < int'(n); i++) begin
                case (o)
                    2'b00: begin
                        a = s + 6'(i); w = ref_mem[a];
                        expq.push_back(mk(1'b1, 1'b0, a, 64'd0, 7'(i)));
                        a = d + 6'(i);
                        expq.push_back(mk(1'b0, 1'b1, a, w, 7'(i)));
                        ref_mem[a] = w;
                    end
                    2'b01: begin
                        a = d + 6'(i);
                        expq.push_back(mk(1'b0, 1'b1, a, f, 7'(i)));
                        ref_mem[a] = f;
                    end
                    default: begin
                        a = s + 6'(i);
                        expq.push_back(mk(1'b1, 1'b0, a, 64'd0, 7'(i)));
                        chk_model = chk_model ^ ref_mem[a];
                    end
                endcase
            end
        end
        e = mk(1'b0, 1'b0, 6'd0, 64'd0, (o == 2'b11) ? 7'd0 : n);
        e.done = 1'b1; e.err = (o == 2'b11); e.chk_v = 1'b1; e.chk = chk_model;
        expq.push_back(e);
    endtask

    // Per-cycle compare against the expected trace; idle when trace is empty.
    always @(negedge clk) begin
        exp_t e;
        if (mem_write) wr_cnt++;
        if (mem_read)  rd_cnt++;
        chk("rw_exclusive", {63'd0, mem_read & mem_write}, 64'd0);
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("mem_read",   {63'd0, mem_read},  {63'd0, e.rd});
            chk("mem_write",  {63'd0, mem_write}, {63'd0, e.wr});
            chk("busy",       {63'd0, busy},      {63'd0, e.busy});
            chk("done",       {63'd0, done},      {63'd0, e.done});
            chk("err",        {63'd0, err},       {63'd0, e.err});
            chk("mem_address", {58'd0, mem_address}, {58'd0, e.addr});
            chk("mem_wdata",  mem_write_data, e.wdata);
            chk("words_done", {57'd0, words_done}, {57'd0, e.wd});
            if (e.chk_v) chk("checksum", checksum, e.chk);
        end else begin
            chk("idle_quiet", {60'd0, busy, done, mem_read, mem_write}, 64'd0);
        end
    end

    task automatic preload(input logic [5:0] a, input logic [63:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1 pl_we = 1'b0;
    endtask

    // Issue a command, push its expected trace, wait for done (bounded).
    task automatic cmd(input logic [1:0] o, input logic [5:0] s, input logic [5:0] d,
                       input logic [6:0] n, input logic [63:0] f,
                       output int lat, output logic err_seen);
        @(negedge clk);
        op = o; src_addr = s; dst_addr = d; len = n; fill_value = f; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        build_trace(o, s, d, n, f);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 300);
        err_seen = err;
        if (!done) chk("done_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic mem_compare(input string name);
        int bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk(name, 64'(bad), 64'd0);
    endtask

    int   lat;
    logic es;
    int   w0, r0;

    initial begin
        rst_n = 1'b0; start = 1'b0; op = '0; src_addr = '0; dst_addr = '0;
        len = '0; fill_value = '0;
        for (int i = 0; i < 64; i++) preload(6'(i), 64'h1000 + 64'(i));
        @(negedge clk);
        #1;
        chk("rst_outputs", {busy, done, err, mem_write, mem_read, 2'b0, mem_address, words_done},
            16'd0);
        chk("rst_checksum", checksum, 64'd0);
        chk("rst_wdata", mem_write_data, 64'd0);
        rst_n = 1'b1;

        // FILL
        w0 = wr_cnt;
        cmd(2'b01, 6'd0, 6'd10, 7'd4, 64'hDEAD_BEEF, lat, es);
        chk("fill_latency", 64'(lat), 64'd5);
        chk("fill_w10", mem[10], 64'hDEAD_BEEF);
        chk("fill_w13", mem[13], 64'hDEAD_BEEF);
        chk("fill_w14", mem[14], 64'h100E);
        chk("fill_wr_cnt", 64'(wr_cnt - w0), 64'd4);
        mem_compare("fill_mem");

        // COPY
        for (int i = 0; i < 4; i++) preload(6'(i), 64'(i + 1));
        cmd(2'b00, 6'd0, 6'd32, 7'd4, 64'd0, lat, es);
        chk("copy_latency", 64'(lat), 64'd9);
        for (int i = 0; i < 4; i++) chk("copy_word", mem[32 + i], 64'(i + 1));
        mem_compare("copy_mem");

        // CHECKSUM with address wrap
        preload(6'd62, 64'd1); preload(6'd63, 64'd2);
        preload(6'd0, 64'd4);  preload(6'd1, 64'd8);
        w0 = wr_cnt;
        cmd(2'b10, 6'd62, 6'd5, 7'd4, 64'd0, lat, es);
        chk("cks_latency", 64'(lat), 64'd5);
        chk("cks_value", checksum, 64'hF);
        chk("cks_words_done", {57'd0, words_done}, 64'd4);
        chk("cks_no_write", 64'(wr_cnt - w0), 64'd0);

        // Illegal op and zero length
        w0 = wr_cnt; r0 = rd_cnt;
        cmd(2'b11, 6'd3, 6'd7, 7'd5, 64'd0, lat, es);
        chk("illegal_latency", 64'(lat), 64'd1);
        chk("illegal_err", {63'd0, es}, 64'd1);
        cmd(2'b00, 6'd3, 6'd7, 7'd0, 64'd0, lat, es);
        chk("len0_latency", 64'(lat), 64'd1);
        chk("len0_err", {63'd0, es}, 64'd0);
        chk("len0_no_access", 64'((wr_cnt - w0) + (rd_cnt - r0)), 64'd0);
        chk("cks_held", checksum, 64'hF);

        // Overlapping forward copy
        preload(6'd0, 64'd7);
        cmd(2'b00, 6'd0, 6'd1, 7'd3, 64'd0, lat, es);
        for (int i = 1; i <= 3; i++) chk("overlap_word", mem[i], 64'd7);
        mem_compare("overlap_mem");

        // FILL aborted by reset, with an ignored second start
        @(negedge clk);
        op = 2'b01; dst_addr = 6'd20; len = 7'd8; fill_value = 64'hA5A5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        w0 = wr_cnt;
        for (int i = 0; i < 4; i++) begin
            expq.push_back(mk(1'b0, 1'b1, 6'(20 + i), 64'hA5A5, 7'(i)));
            ref_mem[20 + i] = 64'hA5A5;
        end
        @(negedge clk);
        @(negedge clk);
        #1 op = 2'b01; dst_addr = 6'd50; len = 7'd2; fill_value = 64'h1; start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_outputs", {busy, done, err, mem_write, mem_read, 2'b0, mem_address, words_done},
            16'd0);
        chk("abort_checksum", checksum, 64'd0);
        chk("abort_wdata", mem_write_data, 64'd0);
        chk("abort_trace_empty", 64'(expq.size()), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("abort_wr_cnt", 64'(wr_cnt - w0), 64'd4);
        chk("abort_w23", mem[23], 64'hA5A5);
        chk("abort_w24", mem[24], 64'h1018);
        mem_compare("abort_mem");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_block_mover.md
Name: dmem_block_mover

Overview:
Initiator-side engine for the 64-entry data memory (6-bit address, 64-bit word, combinational read, write on posedge when the write strobe is high). It accepts one block command at a time from the control path and drives the memory port to perform a block COPY, FILL or read-only XOR checksum. It replaces ad-hoc testbench and CPU-side loops that currently drive address, write_data and mem_write directly.

Parameters:
ADDR_W, 6, memory address width; depth is 2**ADDR_W words
DATA_W, 64, memory word width
LEN_W, ADDR_W+1, transfer length width, so a full-memory transfer (64 words) is encodable

Ports:
clk  in  1  system clock; all state updates on posedge
rst_n  in  1  synchronous active-low reset
start  in  1  command strobe; sampled only in IDLE
op  in  2  00 COPY, 01 FILL, 10 CHECKSUM, 11 illegal
src_addr  in  ADDR_W  first source word (COPY and CHECKSUM)
dst_addr  in  ADDR_W  first destination word (COPY and FILL)
len  in  LEN_W  number of words, 0..64
fill_value  in  DATA_W  pattern for FILL
busy  out  1  high from the cycle after an accepted start until the cycle DONE is entered
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse coincident with done for an illegal op
checksum  out  DATA_W  XOR of all words read by the last CHECKSUM; held until the next CHECKSUM start
words_done  out  LEN_W  words completed in the current or last command
mem_address  out  ADDR_W  memory address
mem_write  out  1  memory write strobe (mem_write of the data memory)
mem_read  out  1  memory read qualifier
mem_write_data  out  DATA_W  memory write data
mem_q  in  DATA_W  memory read data; combinational from mem_address

Behaviour:
- Reset, synchronous on rst_n=0: state=IDLE; busy=0, done=0, err=0, checksum=0, words_done=0; mem_write=0, mem_read=0, mem_address=0, mem_write_data=0. Reset asserted mid-command aborts the command at that edge. No further write strobe is issued, and memory words already written are left as written.
- Memory outputs are decoded from state and registers. mem_write and mem_read are never both 1, and both are 0 in IDLE and DONE.
- States: IDLE, RD, WR, DONE.
- IDLE: when start=1, latch op, src, dst, len and fill_value; clear words_done; for op=10, clear checksum. Next state:
  - len=0 or op=11: DONE; err=1 in DONE when op=11.
  - COPY or CHECKSUM: RD.
  - FILL: WR.
  start=0 keeps IDLE.
- RD: mem_read=1, mem_address=src+words_done (mod 64). At the edge:
  - COPY: capture mem_q into the word buffer, then go to WR.
  - CHECKSUM: checksum ^= mem_q and words_done++. Stay in RD until words_done reaches len, then go to DONE.
- WR: mem_write=1, mem_address=dst+words_done (mod 64); mem_write_data=buffer for COPY, fill_value for FILL. At the edge, words_done++.
  - COPY: go to RD, or to DONE after the last word.
  - FILL: stay in WR, or go to DONE after the last word.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in DONE.
- Latency: COPY takes 2*len+1 cycles from the accepted start edge to the done pulse; FILL and CHECKSUM take len+1; len=0 takes 1.
- Address arithmetic wraps modulo 2**ADDR_W. For example, src=62 with len=4 reads 62, 63, 0, 1.
- COPY runs in ascending address order with no overlap detection. When dst is in (src, src+len), earlier copied words propagate forward; this is the defined behaviour.
- start while busy or in DONE is ignored, with no queueing. Command inputs only need to be stable during the start cycle.
- len>64 is not checked. The command runs len iterations and addresses wrap.

Decomposition:
- Shared package dmem_pkg: ADDR_W/DATA_W constants, op encoding enum (OP_COPY, OP_FILL, OP_CHECKSUM, OP_ILLEGAL), FSM state enum.
- No sub-module needed. The address generator (base + words_done, wrapping) stays inline. The bench instantiates the existing data memory as the responder.

Test Plan:
- Reset, then FILL dst=10 len=4 fill=64'hDEAD_BEEF -> words 10..13 = DEADBEEF, word 14 unchanged; done pulses 5 cycles after the start edge; exactly 4 mem_write cycles.
- Preload words 0..3 = 1,2,3,4, then COPY src=0 dst=32 len=4 -> words 32..35 = 1,2,3,4; done 9 cycles after start; RD and WR alternate with no cycle where both mem_read and mem_write are high.
- CHECKSUM src=62 len=4 with words 62,63,0,1 = 1,2,4,8 -> addresses 62,63,0,1 read in order; checksum=64'hF; words_done=4; mem_write never asserted.
- op=11 len=5 and a separate op=00 len=0 -> the illegal op gives done and err together 1 cycle after start; len=0 gives done with err=0; no memory access in either case.
- Overlapping COPY src=0 dst=1 len=3 with word0=7 -> words 1..3 = 7 (forward propagation).
- FILL len=8, with start re-pulsed mid-command and rst_n=0 on cycle 4 -> the second start is ignored; after reset all outputs are 0 and no mem_write is seen; exactly the words written before the reset edge are modified.
